// File: rtl/mp_regfile.sv
// mp_regfile
// Multi-port integer register file with write-through bypass and a per-register
// busy scoreboard. It sits between decode/issue, which reads operands and
// allocates destinations, and writeback, which retires results.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   we/waddr/wdata      NWR write ports, port k at [k*AW +: AW] / [k*XLEN +: XLEN]
//   ren/raddr           NRD read ports
//   rdata/rbusy         combinational read data and busy status per read port
//   alloc_en/alloc_addr issue-time allocation of a destination (sets busy)
//   dbg_addr/dbg_data   registered, unbypassed snapshot of one register
//
// Register 0 is hardwired to zero and is never busy.
module mp_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD-1:0]      ren,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [XLEN-1:0]  dbg_q;
  logic [XLEN-1:0]  dbg_d;

  // Next-state storage. Ports are visited in ascending order so the
  // highest-index enabled port to a given address is the last to assign it.
  // The allocation is applied after the writes so a same-cycle allocate of a
  // register being retired leaves it busy (a newer producer was issued).
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && (waddr[k*AW +: AW] != '0)) begin
        regs_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
        busy_d[waddr[k*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != '0)) begin
      busy_d[alloc_addr] = 1'b1;
    end
    dbg_d = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_d[r] = '0;
      end
      busy_d = '0;
      dbg_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      regs_q[r] <= regs_d[r];
    end
    busy_q <= busy_d;
    dbg_q  <= dbg_d;
  end

  // Read ports: storage value unless an enabled write targets the same
  // address this cycle, in which case the highest-index writer's data is
  // forwarded and the register is reported as not busy (the clear it is
  // about to receive is already visible).
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      if (!rst && ren[j] && (raddr[j*AW +: AW] != '0)) begin
        rdata[j*XLEN +: XLEN] = regs_q[raddr[j*AW +: AW]];
        rbusy[j]              = busy_q[raddr[j*AW +: AW]];
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (waddr[k*AW +: AW] == raddr[j*AW +: AW])) begin
            rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
            rbusy[j]              = 1'b0;
          end
        end
      end
    end
  end

  assign dbg_data = dbg_q;

endmodule

// File: tb/tb_mp_regfile.sv
// tb_mp_regfile
// Directed bench for mp_regfile. A behavioural model (plain arrays) tracks the
// architectural state and is compared against every read port and the debug
// port on each falling edge; hand-computed literals pin the model itself.
module tb_mp_regfile;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD-1:0]      ren;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  logic [XLEN-1:0] mRegs [NREGS];
  bit              mBusy [NREGS];
  logic [XLEN-1:0] mDbg;

  mp_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .ren        (ren),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model of what a read port must return: zero for reset, disabled port or
  // x0; otherwise the highest-numbered port writing that address, else the
  // stored value.
  function automatic logic [XLEN-1:0] expData(input int j);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    if (rst || !ren[j] || a == 0) return '0;
    for (int k = NWR - 1; k >= 0; k--)
      if (we[k] && waddr[k*AW +: AW] == a) return wdata[k*XLEN +: XLEN];
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input int j);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    if (rst || !ren[j] || a == 0) return 1'b0;
    for (int k = 0; k < NWR; k++)
      if (we[k] && waddr[k*AW +: AW] == a) return 1'b0;
    return mBusy[a];
  endfunction

  // Architectural state update at each rising edge.
  always @(posedge clk) begin
    bit claimed [NREGS];
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mRegs[r] = '0;
        mBusy[r] = 1'b0;
      end
      mDbg = '0;
    end else begin
      mDbg = (dbg_addr == 0) ? '0 : mRegs[dbg_addr];
      for (int r = 0; r < NREGS; r++) claimed[r] = 1'b0;
      for (int k = NWR - 1; k >= 0; k--) begin
        if (we[k] && waddr[k*AW +: AW] != 0 && !claimed[waddr[k*AW +: AW]]) begin
          claimed[waddr[k*AW +: AW]] = 1'b1;
          mRegs[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
          mBusy[waddr[k*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 0) mBusy[alloc_addr] = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int j = 0; j < NRD; j++) begin
        checkOutput($sformatf("model_rdata%0d", j), rdata[j*XLEN +: XLEN], expData(j));
        checkOutput($sformatf("model_rbusy%0d", j), {63'd0, rbusy[j]}, {63'd0, expBusy(j)});
      end
      checkOutput("model_dbg", dbg_data, mDbg);
    end
  end

  // Advance one cycle and return the inputs to idle, just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    ren      = '0;
    raddr    = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic setWrite(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[k] = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*XLEN +: XLEN] = d;
  endtask

  task automatic setRead(input int j, input logic [AW-1:0] a);
    ren[j] = 1'b1;
    raddr[j*AW +: AW] = a;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
    alloc_en = 1'b0; alloc_addr = '0; dbg_addr = 5'd5;
    setWrite(0, 5, 64'h1111); setWrite(1, 5, 64'h2222); setRead(0, 5);

    // Second reset cycle, writes still asserted.
    applyStimulus();
    checkEn = 1'b1;
    rst = 1'b1;
    setWrite(0, 5, 64'h1111); setWrite(1, 5, 64'h2222); setRead(0, 5); setRead(1, 5);
    settle();
    checkOutput("rst_rdata0", rdata[0 +: XLEN], 64'h0);

    applyStimulus();
    setRead(0, 5); setRead(1, 5);
    settle();
    checkOutput("post_rst_x5", rdata[XLEN +: XLEN], 64'h0);
    checkOutput("post_rst_busy", {62'd0, rbusy}, 64'h0);
    checkOutput("post_rst_dbg", dbg_data, 64'h0);

    // Write x7 with same-cycle bypass, then read from storage.
    applyStimulus();
    setWrite(0, 7, 64'h1234); setRead(1, 7);
    settle();
    checkOutput("bypass_x7", rdata[XLEN +: XLEN], 64'h1234);
    applyStimulus();
    setRead(1, 7);
    settle();
    checkOutput("stored_x7", rdata[XLEN +: XLEN], 64'h1234);

    // Two ports to x3: port1 wins.
    applyStimulus();
    setWrite(0, 3, 64'hAAAA); setWrite(1, 3, 64'h5555); setRead(0, 3);
    settle();
    checkOutput("conflict_bypass_x3", rdata[0 +: XLEN], 64'h5555);
    applyStimulus();
    setRead(0, 3); setRead(1, 7);
    settle();
    checkOutput("conflict_stored_x3", rdata[0 +: XLEN], 64'h5555);

    // x0 ignores writes and allocation.
    applyStimulus();
    dbg_addr = 5'd0;
    setWrite(0, 0, 64'hFFFF); setWrite(1, 0, 64'hFFFF);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    setRead(0, 0); setRead(1, 0);
    settle();
    checkOutput("x0_rdata1", rdata[XLEN +: XLEN], 64'h0);
    applyStimulus();
    setRead(0, 0); setRead(1, 0);
    settle();
    checkOutput("x0_rbusy", {62'd0, rbusy}, 64'h0);
    checkOutput("x0_dbg", dbg_data, 64'h0);

    // Scoreboard on x9: alloc at t, busy visible at t+1, cleared by write at t+3.
    applyStimulus();
    alloc_en = 1'b1; alloc_addr = 5'd9; setRead(0, 9);
    settle();
    checkOutput("x9_busy_t", {63'd0, rbusy[0]}, 64'h0);
    applyStimulus();
    setRead(0, 9);
    settle();
    checkOutput("x9_busy_t1", {63'd0, rbusy[0]}, 64'h1);
    applyStimulus();
    setRead(1, 9);
    settle();
    applyStimulus();
    setWrite(1, 9, 64'h42); setRead(0, 9);
    settle();
    checkOutput("x9_busy_t3", {63'd0, rbusy[0]}, 64'h0);
    checkOutput("x9_data_t3", rdata[0 +: XLEN], 64'h42);
    applyStimulus();
    setRead(0, 9);
    settle();
    checkOutput("x9_busy_t4", {63'd0, rbusy[0]}, 64'h0);
    checkOutput("x9_data_t4", rdata[0 +: XLEN], 64'h42);

    // Alloc/write race on x4.
    applyStimulus();
    alloc_en = 1'b1; alloc_addr = 5'd4;
    applyStimulus();
    setRead(0, 4);
    settle();
    checkOutput("x4_busy", {63'd0, rbusy[0]}, 64'h1);
    applyStimulus();
    setWrite(0, 4, 64'h77); alloc_en = 1'b1; alloc_addr = 5'd4; setRead(1, 4);
    settle();
    checkOutput("race_bypass", rdata[XLEN +: XLEN], 64'h77);
    applyStimulus();
    dbg_addr = 5'd4; setRead(0, 4);
    settle();
    checkOutput("race_busy", {63'd0, rbusy[0]}, 64'h1);
    checkOutput("race_data", rdata[0 +: XLEN], 64'h77);
    applyStimulus();
    settle();
    checkOutput("race_dbg", dbg_data, 64'h77);

    // Disabled read port returns zero even for a written register.
    applyStimulus();
    setWrite(0, 12, 64'h99); raddr[0 +: AW] = 5'd12;
    settle();
    checkOutput("ren_off", rdata[0 +: XLEN], 64'h0);

    // Mid-operation reset discards busy state and contents.
    applyStimulus();
    alloc_en = 1'b1; alloc_addr = 5'd10;
    applyStimulus();
    rst = 1'b1; setRead(0, 10); setRead(1, 7);
    settle();
    checkOutput("midrst_rdata", rdata[XLEN +: XLEN], 64'h0);
    checkOutput("midrst_rbusy", {63'd0, rbusy[0]}, 64'h0);
    applyStimulus();
    setRead(0, 10); setRead(1, 7);
    settle();
    checkOutput("after_midrst_busy", {63'd0, rbusy[0]}, 64'h0);
    checkOutput("after_midrst_x7", rdata[XLEN +: XLEN], 64'h0);

    applyStimulus();
    settle();
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
